// File: rtl/if_issue_queue_pkg.sv
// Shared fetch-to-decode bus definitions and issue-queue geometry.
// Also provides a small helper that counts the valid lanes of a two-lane bus.
package if_issue_queue_pkg;

  localparam int FETCH_LANES    = 2;
  localparam int ENTRY_W        = 96;
  localparam int FS_TO_IQ_BUS_W = FETCH_LANES * ENTRY_W;
  localparam int DEPTH          = 4;
  localparam int PTR_W          = 2;
  localparam int CNT_W          = 3;

  function automatic logic [CNT_W-1:0] lane_count(input logic lane1, input logic lane2);
    return {2'b00, lane1} + {2'b00, lane2};
  endfunction

endpackage

// File: rtl/if_issue_queue_if.sv
// Fetch-side and decode-side handshake bundle of the issue queue.
// master drives fetch/decode control, slave is the queue itself.
interface if_issue_queue_if #(
  parameter int ENTRY_W = if_issue_queue_pkg::ENTRY_W
);

  logic                   in_line1_valid_i;
  logic                   in_line2_valid_i;
  logic [2*ENTRY_W-1:0]   in_bus_i;
  logic                   in_allowin_o;
  logic                   next_allowin_i;
  logic                   line1_valid_o;
  logic                   line2_valid_o;
  logic [2*ENTRY_W-1:0]   to_next_obus;
  logic                   excep_flush_i;
  logic                   branch_flush_i;
  logic [2:0]             count_o;

  modport master (
    output in_line1_valid_i, in_line2_valid_i, in_bus_i, next_allowin_i,
           excep_flush_i, branch_flush_i,
    input  in_allowin_o, line1_valid_o, line2_valid_o, to_next_obus, count_o
  );

  modport slave (
    input  in_line1_valid_i, in_line2_valid_i, in_bus_i, next_allowin_i,
           excep_flush_i, branch_flush_i,
    output in_allowin_o, line1_valid_o, line2_valid_o, to_next_obus, count_o
  );

endinterface

// File: rtl/if_issue_queue.sv
// Four-entry, two-in/two-out circular issue queue between fetch and decode.
// allowin is derived from the registered count only, so decode never stalls fetch combinationally.
module if_issue_queue #(
  parameter int ENTRY_W = if_issue_queue_pkg::ENTRY_W,
  parameter int DEPTH   = if_issue_queue_pkg::DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  if_issue_queue_if.slave bus
);

  import if_issue_queue_pkg::*;

  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [ENTRY_W-1:0] entry_r [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [PTR_W-1:0]   wr_ptr_nxt_s;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [CNT_W-1:0]   enq_num_s;
  logic [CNT_W-1:0]   deq_num_s;
  logic [PTR_W-1:0]   lane2_slot_s;
  logic [PTR_W-1:0]   rd_ptr_plus1_s;
  logic               flush_s;
  logic               allowin_s;
  logic               enq_s;
  logic               line1_valid_s;
  logic               line2_valid_s;

  // Handshake decode and next-state arithmetic; a flush overrides both enqueue and dequeue.
  always_comb begin
    flush_s        = bus.excep_flush_i | bus.branch_flush_i;
    allowin_s      = (count_r <= 3'd2);
    enq_s          = allowin_s & (bus.in_line1_valid_i | bus.in_line2_valid_i) & ~flush_s;
    line1_valid_s  = (count_r >= 3'd1) & ~flush_s;
    line2_valid_s  = (count_r >= 3'd2) & ~flush_s;
    enq_num_s      = enq_s ? lane_count(bus.in_line1_valid_i, bus.in_line2_valid_i) : 3'd0;
    deq_num_s      = bus.next_allowin_i ? lane_count(line1_valid_s, line2_valid_s) : 3'd0;
    lane2_slot_s   = bus.in_line1_valid_i ? (wr_ptr_r + 2'd1) : wr_ptr_r;
    rd_ptr_plus1_s = rd_ptr_r + 2'd1;
    rd_ptr_nxt_s   = rd_ptr_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    count_nxt_s    = count_r;
    if (flush_s) begin
      rd_ptr_nxt_s = 2'd0;
      wr_ptr_nxt_s = 2'd0;
      count_nxt_s  = 3'd0;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + deq_num_s[PTR_W-1:0];
      wr_ptr_nxt_s = wr_ptr_r + enq_num_s[PTR_W-1:0];
      count_nxt_s  = count_r + enq_num_s - deq_num_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= 2'd0;
      wr_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Payload storage is never reset: a slot is only visible while count covers it.
  always_ff @(posedge clk) begin
    if (enq_s && bus.in_line1_valid_i) begin
      entry_r[wr_ptr_r] <= bus.in_bus_i[ENTRY_W-1:0];
    end
    if (enq_s && bus.in_line2_valid_i) begin
      entry_r[lane2_slot_s] <= bus.in_bus_i[2*ENTRY_W-1:ENTRY_W];
    end
  end

  assign bus.in_allowin_o  = allowin_s;
  assign bus.line1_valid_o = line1_valid_s;
  assign bus.line2_valid_o = line2_valid_s;
  assign bus.count_o       = count_r;
  assign bus.to_next_obus  = {(line2_valid_s ? entry_r[rd_ptr_plus1_s] : {ENTRY_W{1'b0}}),
                              (line1_valid_s ? entry_r[rd_ptr_r]       : {ENTRY_W{1'b0}})};

endmodule

// File: tb/tb_if_issue_queue.sv
// Randomized bench for if_issue_queue against a queue-based reference model.
module tb_if_issue_queue;

  import if_issue_queue_pkg::*;

  localparam int EW = ENTRY_W;
  localparam int BW = 2 * EW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: plain FIFO of entries in issue order.
  logic [EW-1:0] mq [$];

  if_issue_queue_if #(.ENTRY_W(EW)) bus ();

  if_issue_queue #(.ENTRY_W(EW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] rnd_entry(input logic [31:0] pc);
    return {$urandom(), $urandom(), pc};
  endfunction

  task automatic drive(input logic v1, input logic v2, input logic [EW-1:0] d1,
                       input logic [EW-1:0] d2, input logic na, input logic ef, input logic bf);
    bus.in_line1_valid_i = v1;
    bus.in_line2_valid_i = v2;
    bus.in_bus_i         = {d2, d1};
    bus.next_allowin_i   = na;
    bus.excep_flush_i    = ef;
    bus.branch_flush_i   = bf;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"},   BW'(bus.count_o),       BW'(3'd0));
    chk({tag, "_allowin"}, BW'(bus.in_allowin_o),  BW'(1'b1));
    chk({tag, "_l1v"},     BW'(bus.line1_valid_o), BW'(1'b0));
    chk({tag, "_l2v"},     BW'(bus.line2_valid_o), BW'(1'b0));
    chk({tag, "_obus"},    bus.to_next_obus,       {BW{1'b0}});
  endtask

  // One cycle: drive at negedge, check outputs against the model, advance the model.
  task automatic step(input logic v1, input logic v2, input logic [EW-1:0] d1,
                      input logic [EW-1:0] d2, input logic na, input logic ef, input logic bf);
    int            sz;
    logic          flush;
    logic          e1;
    logic          e2;
    logic [BW-1:0] eb;
    @(negedge clk);
    drive(v1, v2, d1, d2, na, ef, bf);
    #1;
    sz    = mq.size();
    flush = ef | bf;
    e1    = (sz >= 1) && !flush;
    e2    = (sz >= 2) && !flush;
    eb    = {BW{1'b0}};
    if (e1) eb[EW-1:0]  = mq[0];
    if (e2) eb[BW-1:EW] = mq[1];
    chk("in_allowin",  BW'(bus.in_allowin_o),  BW'(sz <= 2));
    chk("count",       BW'(bus.count_o),       BW'(sz));
    chk("line1_valid", BW'(bus.line1_valid_o), BW'(e1));
    chk("line2_valid", BW'(bus.line2_valid_o), BW'(e2));
    chk("obus",        bus.to_next_obus,       eb);
    if (flush) begin
      mq.delete();
    end else begin
      if (na && e1) void'(mq.pop_front());
      if (na && e2) void'(mq.pop_front());
      if (sz <= 2) begin
        if (v1) mq.push_back(d1);
        if (v2) mq.push_back(d2);
      end
    end
  endtask

  task automatic idle(input logic na);
    step(1'b0, 1'b0, {EW{1'b0}}, {EW{1'b0}}, na, 1'b0, 1'b0);
  endtask

  task automatic rnd_step(input int flush_odds);
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         rnd_entry($urandom()), rnd_entry($urandom()),
         1'($urandom_range(0, 2) != 0),
         1'($urandom_range(0, flush_odds) == 0),
         1'($urandom_range(0, flush_odds) == 0));
  endtask

  initial begin
    logic [EW-1:0] lane2_only;
    drive(1'b0, 1'b0, {EW{1'b0}}, {EW{1'b0}}, 1'b0, 1'b0, 1'b0);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Dual fetch with decode ready: both pcs visible next cycle, queue empty after.
    step(1'b1, 1'b1, rnd_entry(32'h1c00_0000), rnd_entry(32'h1c00_0004), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("pc_lane1", BW'(bus.to_next_obus[31:0]),       BW'(32'h1c00_0000));
    chk("pc_lane2", BW'(bus.to_next_obus[EW+31:EW]),   BW'(32'h1c00_0004));
    idle(1'b1);

    // Decode stalled: three dual fetches, the third is refused.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, rnd_entry($urandom()), rnd_entry($urandom()), 1'b0, 1'b0, 1'b0);
    end
    idle(1'b0);
    chk("full_count",   BW'(bus.count_o),      BW'(3'd4));
    chk("full_allowin", BW'(bus.in_allowin_o), BW'(1'b0));

    // Branch flush at full with valid fetch input: everything dropped.
    step(1'b1, 1'b1, rnd_entry($urandom()), rnd_entry($urandom()), 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("flush_count", BW'(bus.count_o), BW'(3'd0));

    // Lane-2-only fetch into an empty queue.
    lane2_only = rnd_entry(32'h1c00_0100);
    step(1'b0, 1'b1, rnd_entry($urandom()), lane2_only, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("lane2_only_l1", BW'(bus.to_next_obus[EW-1:0]), BW'(lane2_only));
    idle(1'b1);

    // Random traffic with occasional flushes, exercising pointer wrap.
    for (int i = 0; i < 3000; i++) rnd_step(24);

    // Asynchronous reset mid-cycle at count 3.
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 1'b1, rnd_entry($urandom()), rnd_entry($urandom()), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, rnd_entry($urandom()), rnd_entry($urandom()), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_reset_count", BW'(bus.count_o), BW'(3'd3));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mq.delete();
    drive(1'b0, 1'b0, {EW{1'b0}}, {EW{1'b0}}, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);

    for (int i = 0; i < 1000; i++) rnd_step(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_issue_queue.md
IF_ISSUE_QUEUE -- requirements
Module: if_issue_queue

Interface
REQ-001 Parameter ENTRY_W, default 96, SHALL be the width of one instruction entry (pc, inst, exception info).
REQ-002 Parameter DEPTH, default 4, SHALL be the number of queue entries; only DEPTH=4 is supported.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_line1_valid_i  in  1  SHALL mark fetch lane 1 as carrying an instruction.
REQ-006 in_line2_valid_i  in  1  SHALL mark fetch lane 2 as carrying an instruction.
REQ-007 in_bus_i  in  2*ENTRY_W  SHALL carry the fetch lanes: lane 1 in bits [ENTRY_W-1:0], lane 2 in the upper half.
REQ-008 in_allowin_o  out  1  SHALL tell fetch that the queue accepts up to two entries this cycle.
REQ-009 next_allowin_i  in  1  SHALL be the decode-stage allowin; high means decode accepts the presented lanes this cycle.
REQ-010 line1_valid_o  out  1  SHALL mark issue lane 1 as valid toward decode.
REQ-011 line2_valid_o  out  1  SHALL mark issue lane 2 as valid toward decode.
REQ-012 to_next_obus  out  2*ENTRY_W  SHALL carry the issue lanes, using the same lane packing as in_bus_i.
REQ-013 excep_flush_i  in  1  SHALL request a flush on an exception.
REQ-014 branch_flush_i  in  1  SHALL request a flush on a branch mispredict.
REQ-015 count_o  out  3  SHALL report current occupancy, 0..4.

Function
REQ-016 Storage SHALL be a 4-entry circular buffer with 2-bit rd_ptr and wr_ptr that wrap modulo 4, plus a 3-bit count.
REQ-017 in_allowin_o SHALL equal (count <= 2); it depends on registered state only and SHALL have no combinational path from next_allowin_i.
REQ-018 Enqueue condition: in_allowin_o and (v1|v2) and no flush.
- Lane 1 is written at wr_ptr if v1.
- Lane 2 is written at the next free slot: wr_ptr+1 if v1, otherwise wr_ptr.
- wr_ptr advances by v1+v2.
REQ-019 line1_valid_o SHALL be (count>=1) and not flush.
REQ-020 line2_valid_o SHALL be (count>=2) and not flush.
REQ-021 Lane 1 of to_next_obus SHALL be entry[rd_ptr] and lane 2 SHALL be entry[rd_ptr+1]; each half SHALL be zero when its lane is invalid.
REQ-022 Dequeue: when next_allowin_i is high, rd_ptr SHALL advance by line1_valid_o+line2_valid_o; when low, outputs SHALL hold unchanged.
REQ-023 Next count SHALL be count + enq - deq, evaluated in the same cycle.
- Simultaneous enqueue and dequeue is legal; the dequeue reads the entries present before the edge.
- Overflow is impossible by REQ-017.
REQ-024 Latency: an entry enqueued at edge N SHALL be presented to decode from cycle N+1.
REQ-025 Flush (either flush input high) SHALL clear count, rd_ptr and wr_ptr at the next edge and SHALL suppress that cycle's enqueue and dequeue.
REQ-026 A flush coincident with valid fetch input SHALL drop that input; in_allowin_o is unaffected by the flush.
REQ-027 Lane order SHALL be preserved: the issue order equals the enqueue order across wrap-around.

Reset
REQ-028 While rst_n is low:
- count, rd_ptr and wr_ptr SHALL be 0.
- line1_valid_o, line2_valid_o, to_next_obus and count_o SHALL be 0.
- in_allowin_o SHALL be 1.
REQ-029 Entry storage need not be reset; it SHALL never be observable while invalid (REQ-021).
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately, with no further issue after reset releases until new enqueues occur.

Structure
REQ-031 ENTRY_W, DEPTH and PTR_W=2 SHALL live in the shared bus-definition package next to the fetch-bus width definitions.
REQ-032 The block SHALL be a single module with no sub-modules; storage is a register array inside if_issue_queue.

Verification
REQ-033 Reset, then fetch 2 lanes (pc 0x1c000000, 0x1c000004) with next_allowin_i=1 -> both lanes valid next cycle with the matching pc values; count_o=0 after the following edge.
REQ-034 next_allowin_i=0, three dual fetches -> count_o goes 2, 4; in_allowin_o=0 at count 4; the third fetch is not accepted; lane data holds steady.
REQ-035 Lane-2-only fetch (in_line1_valid_i=0) into an empty queue -> count_o=1, line1_valid_o=1 carrying the lane-2 data, line2_valid_o=0, upper half of to_next_obus=0.
REQ-036 Count 3 after wrap (rd_ptr=3), next_allowin_i=1 -> issue order 3,0, then 1; no reorder.
REQ-037 branch_flush_i pulse at count 4 with valid fetch input -> both valids 0 in the flush cycle, count_o=0 next cycle, fetched lanes discarded.
REQ-038 rst_n dropped asynchronously mid-cycle at count 3 -> outputs zero immediately; after release, valids stay 0 until a new enqueue.
